poly_horner_eval: RTL

//  Parametrised, sequential successor to the fixed combinational polynomial

---
 rtl/poly_horner_eval.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/poly_horner_eval.sv
// -----------------------------------------------------------------------------
// poly_horner_eval
//   Sequential polynomial evaluator: y = k + sum(c[i] * x^i), i = 0..DEG,
//   all arithmetic modulo 2^W. Horner's method, one multiply-add per cycle.
//   Coefficients live in a small writable register file.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   coef_we/idx/wdata     coefficient write port (only honoured in IDLE)
//   in_valid/in_ready     operand handshake, carries in_x and in_k
//   out_valid/out_ready   result handshake, carries out_y
// -----------------------------------------------------------------------------
module poly_horner_eval #(
    parameter int XW  = 2,
    parameter int W   = 5,
    parameter int DEG = 3,
    parameter int IW  = (DEG > 0) ? $clog2(DEG + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we,
    input  logic [IW-1:0] coef_idx,
    input  logic [W-1:0]  coef_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [W-1:0]  in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y
);

    // state | meaning
    // IDLE  | waiting for an operand; coefficient writes allowed
    // CALC  | one Horner multiply-add per edge, cnt walks DEG-1 down to 0
    // DONE  | result presented, held until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    coef [0:DEG];
    logic [W-1:0]    acc;
    logic [W-1:0]    k_r;
    logic [W-1:0]    y_r;
    logic [XW-1:0]   x_r;
    logic [IW-1:0]   cnt;

    logic            accept;
    logic            wr_en;
    logic [W-1:0]    c_top;
    logic [W-1:0]    c_cnt;
    logic [W-1:0]    mac;

    assign accept = in_valid && (state == IDLE);
    assign wr_en  = coef_we && (state == IDLE) && (32'(coef_idx) <= 32'(DEG));

    // Forward a same-edge write of the top coefficient so an evaluation
    // accepted together with that write starts from the new value.
    assign c_top = (wr_en && (coef_idx == IW'(DEG))) ? coef_wdata : coef[DEG];

    always_comb begin
        c_cnt = '0;
        for (int i = 0; i <= DEG; i++) begin
            if (cnt == IW'(i)) begin
                c_cnt = coef[i];
            end
        end
    end

    // k is folded in on the final step only.
    assign mac = acc * W'(x_r) + c_cnt + ((cnt == '0) ? k_r : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (DEG == 0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DEG; i++) begin
                coef[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= DEG; i++) begin
                if (wr_en && (coef_idx == IW'(i))) begin
                    coef[i] <= coef_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            x_r <= '0;
            k_r <= '0;
            y_r <= '0;
        end else if (accept) begin
            x_r <= in_x;
            k_r <= in_k;
            if (DEG == 0) begin
                acc <= c_top + in_k;
                y_r <= c_top + in_k;
            end else begin
                acc <= c_top;
                cnt <= IW'(DEG - 1);
            end
        end else if (state == CALC) begin
            acc <= mac;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                y_r <= mac;
            end
        end
    end

    // Registered separately from acc so the output only moves on DONE entry.
    assign out_y = y_r;

endmodule
